// File: rtl/alarm_zone_scheduler_pkg.sv
// Shared constants, FSM encoding and zone-selection helpers for the alarm zone scheduler.
package alarm_pkg;

    localparam int unsigned BUZZ_CYCLES_DEF = 100;
    localparam int unsigned GAP_CYCLES_DEF  = 10;

    localparam logic [1:0] ZONE_NONE = 2'b11;

    // 7-segment patterns, active-high, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BUZZ = 3'b010,
        ST_GAP  = 3'b100
    } state_e;

    function automatic logic [1:0] next_zone(input logic [1:0] z);
        return (z == 2'd2) ? 2'd0 : z + 2'd1;
    endfunction

    function automatic logic zone_bit(input logic [2:0] v, input logic [1:0] z);
        case (z)
            2'd0:    return v[0];
            2'd1:    return v[1];
            2'd2:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] zone_mask(input logic [1:0] z);
        case (z)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Round-robin search starting one past the last served zone.
    function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
        logic [1:0] z0, z1, z2;
        z0 = next_zone(last);
        z1 = next_zone(z0);
        z2 = next_zone(z1);
        if (zone_bit(pend, z0))      return z0;
        else if (zone_bit(pend, z1)) return z1;
        else if (zone_bit(pend, z2)) return z2;
        else                         return ZONE_NONE;
    endfunction

endpackage

// File: rtl/alarm_zone_scheduler_if.sv
// Operator, sensor and annunciator signals of the alarm zone scheduler.
interface alarm_zone_scheduler_if;

    logic        arm;
    logic        stop_alarm;
    logic        pir_sensor_1;
    logic        pir_sensor_2;
    logic        pir_sensor_3;
    logic        LED;
    logic        buzzer;
    logic [1:0]  zone_id;
    logic [20:0] display_data;

    modport master (
        output arm, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
        input  LED, buzzer, zone_id, display_data
    );

    modport slave (
        input  arm, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
        output LED, buzzer, zone_id, display_data
    );

endinterface

// File: rtl/pir_sync_edge.sv
// Two-flop synchronizer for an asynchronous PIR input plus a rising-edge pulse.
module pir_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1, sync2, sync2_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= async_in;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/alarm_zone_scheduler.sv
// Three-zone PIR alarm: latches motion events per zone and sounds them one at a
// time, round-robin, with a fixed buzz period followed by a silent gap.
module alarm_zone_scheduler
    import alarm_pkg::*;
#(
    parameter int unsigned BUZZ_CYCLES = BUZZ_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alarm_zone_scheduler_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (BUZZ_CYCLES > GAP_CYCLES) ? BUZZ_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUZZ_LAST = CNT_W'(BUZZ_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]       rise;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pending_q, pending_d;
    logic [1:0]       granted_q, granted_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       clear_mask;

    pir_sync_edge u_sync0 (.clk(clk), .rst_n(rst_n), .async_in(bus.pir_sensor_1), .rise(rise[0]));
    pir_sync_edge u_sync1 (.clk(clk), .rst_n(rst_n), .async_in(bus.pir_sensor_2), .rise(rise[1]));
    pir_sync_edge u_sync2 (.clk(clk), .rst_n(rst_n), .async_in(bus.pir_sensor_3), .rise(rise[2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            granted_q <= 2'd0;
            last_q    <= 2'd2;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            granted_q <= granted_d;
            last_q    <= last_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        granted_d  = granted_q;
        last_d     = last_q;
        clear_mask = '0;

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    granted_d = rr_pick(pending_q, last_q);
                    state_d   = ST_BUZZ;
                    cnt_d     = '0;
                end
            end
            ST_BUZZ: begin
                if (bus.stop_alarm || cnt_q == BUZZ_LAST) begin
                    state_d    = ST_GAP;
                    cnt_d      = '0;
                    clear_mask = zone_mask(granted_q);
                    last_d     = granted_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A fresh edge is OR-ed in after the clear so it survives a coincident clear.
        pending_d = (pending_q & ~clear_mask) | rise;

        if (!bus.arm) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pending_d = '0;
        end
    end

    assign bus.LED          = (state_q == ST_BUZZ);
    assign bus.buzzer       = (state_q == ST_BUZZ);
    assign bus.zone_id      = (state_q == ST_BUZZ) ? granted_q : ZONE_NONE;
    assign bus.display_data = {pending_q[2] ? SEG_3 : SEG_BLANK,
                               pending_q[1] ? SEG_2 : SEG_BLANK,
                               pending_q[0] ? SEG_1 : SEG_BLANK};

endmodule

// File: tb/tb_alarm_zone_scheduler.sv
// Directed self-checking bench for alarm_zone_scheduler with default timing parameters.
module tb_alarm_zone_scheduler;

    localparam logic [6:0] D1 = 7'b0000110;
    localparam logic [6:0] D2 = 7'b1011011;
    localparam logic [6:0] D3 = 7'b1001111;
    localparam logic [1:0] NONE = 2'b11;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alarm_zone_scheduler_if bus ();

    alarm_zone_scheduler #(.BUZZ_CYCLES(100), .GAP_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] disp(input logic p2, input logic p1, input logic p0);
        return {p2 ? D3 : 7'b0, p1 ? D2 : 7'b0, p0 ? D1 : 7'b0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic on, input logic [1:0] zone,
                             input logic [20:0] dsp);
        check({tag, ".led"},     32'(bus.LED),          32'(on));
        check({tag, ".buzzer"},  32'(bus.buzzer),       32'(on));
        check({tag, ".zone_id"}, 32'(bus.zone_id),      32'(zone));
        check({tag, ".display"}, 32'(bus.display_data), 32'(dsp));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.arm = 1'b0;
        bus.stop_alarm = 1'b0;
        bus.pir_sensor_1 = 1'b0;
        bus.pir_sensor_2 = 1'b0;
        bus.pir_sensor_3 = 1'b0;
        #1;
        check_out("reset", 1'b0, NONE, 21'd0);
        step(2);
        rst_n = 1'b1;
        bus.arm = 1'b1;
        step(2);

        // Single zone 1 pulse: latency, duration, gap
        bus.pir_sensor_2 = 1'b1;
        step(3);
        check("a_edge3_buzzer", 32'(bus.buzzer), 32'd0);
        check("a_edge3_display", 32'(bus.display_data), 32'(disp(0, 1, 0)));
        step(1);
        check_out("a_edge4", 1'b1, 2'd1, disp(0, 1, 0));
        step(1);
        bus.pir_sensor_2 = 1'b0;
        step(98);
        check_out("a_edge103", 1'b1, 2'd1, disp(0, 1, 0));
        step(1);
        check_out("a_edge104", 1'b0, NONE, 21'd0);
        step(10);
        check("a_gap_end_buzzer", 32'(bus.buzzer), 32'd0);

        rst_n = 1'b0;
        #1;
        check_out("rst2", 1'b0, NONE, 21'd0);
        step(1);
        rst_n = 1'b1;
        step(1);

        // All three zones at once: served 0,1,2
        bus.pir_sensor_1 = 1'b1;
        bus.pir_sensor_2 = 1'b1;
        bus.pir_sensor_3 = 1'b1;
        step(3);
        check("b_pend_display", 32'(bus.display_data), 32'(disp(1, 1, 1)));
        step(1);
        check_out("b_z0_on", 1'b1, 2'd0, disp(1, 1, 1));
        step(100);
        check_out("b_z0_off", 1'b0, NONE, disp(1, 1, 0));
        step(10);
        check("b_idle1_buzzer", 32'(bus.buzzer), 32'd0);
        step(1);
        check_out("b_z1_on", 1'b1, 2'd1, disp(1, 1, 0));
        step(100);
        check_out("b_z1_off", 1'b0, NONE, disp(1, 0, 0));
        step(11);
        check_out("b_z2_on", 1'b1, 2'd2, disp(1, 0, 0));
        step(100);
        check_out("b_z2_off", 1'b0, NONE, 21'd0);
        bus.pir_sensor_1 = 1'b0;
        bus.pir_sensor_2 = 1'b0;
        bus.pir_sensor_3 = 1'b0;
        step(20);
        check("b_quiet_buzzer", 32'(bus.buzzer), 32'd0);

        // stop_alarm early end; held through GAP and IDLE where it is ignored
        bus.pir_sensor_2 = 1'b1;
        step(4);
        check_out("c_z1_on", 1'b1, 2'd1, disp(0, 1, 0));
        bus.pir_sensor_2 = 1'b0;
        step(6);
        bus.pir_sensor_1 = 1'b1;
        step(5);
        bus.pir_sensor_1 = 1'b0;
        check("c_two_pending", 32'(bus.display_data), 32'(disp(0, 1, 1)));
        step(8);
        bus.stop_alarm = 1'b1;
        step(1);
        check_out("c_stopped", 1'b0, NONE, disp(0, 0, 1));
        step(10);
        check("c_gap_end_buzzer", 32'(bus.buzzer), 32'd0);
        step(1);
        bus.stop_alarm = 1'b0;
        check_out("c_z0_on", 1'b1, 2'd0, disp(0, 0, 1));

        // Zone 0 re-triggered in its own final BUZZ cycle: set wins over clear
        step(97);
        bus.pir_sensor_1 = 1'b1;
        step(2);
        check("d_last_cycle_buzzer", 32'(bus.buzzer), 32'd1);
        step(1);
        check_out("d_set_wins", 1'b0, NONE, disp(0, 0, 1));
        step(10);
        check("d_gap_end_buzzer", 32'(bus.buzzer), 32'd0);
        step(1);
        check_out("d_z0_again", 1'b1, 2'd0, disp(0, 0, 1));

        // Disarm mid-BUZZ with other zones pending, re-arm with sensors held
        bus.pir_sensor_2 = 1'b1;
        bus.pir_sensor_3 = 1'b1;
        step(5);
        check_out("e_all_pending", 1'b1, 2'd0, disp(1, 1, 1));
        bus.arm = 1'b0;
        step(1);
        check_out("e_disarmed", 1'b0, NONE, 21'd0);
        step(3);
        bus.arm = 1'b1;
        step(20);
        check_out("e_rearmed_quiet", 1'b0, NONE, 21'd0);

        // Asynchronous reset mid-BUZZ, then re-trigger from a held sensor
        bus.pir_sensor_1 = 1'b0;
        bus.pir_sensor_2 = 1'b0;
        bus.pir_sensor_3 = 1'b0;
        step(5);
        bus.pir_sensor_3 = 1'b1;
        step(4);
        check_out("f_z2_on", 1'b1, 2'd2, disp(1, 0, 0));
        step(10);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("f_async_reset", 1'b0, NONE, 21'd0);
        step(1);
        rst_n = 1'b1;
        step(3);
        check("f_edge3_buzzer", 32'(bus.buzzer), 32'd0);
        step(1);
        check_out("f_retrigger", 1'b1, 2'd2, disp(1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_zone_scheduler.md
ALARM_ZONE_SCHEDULER -- requirements
Module: alarm_zone_scheduler

Interface
REQ-001 Parameter BUZZ_CYCLES, default 100, number of clk cycles one zone's alarm stays on.
REQ-002 Parameter GAP_CYCLES, default 10, number of silent clk cycles between two zone alarms.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 arm  input  1  1 = system armed; 0 = disarmed, all alarms suppressed.
REQ-006 stop_alarm  input  1  operator acknowledge of the currently sounding zone.
REQ-007 pir_sensor_1 / pir_sensor_2 / pir_sensor_3  input  1 each  asynchronous motion inputs for zones 0/1/2, active-high.
REQ-008 LED  output  1  1 while any zone alarm is sounding.
REQ-009 buzzer  output  1  1 while any zone alarm is sounding; identical timing to LED.
REQ-010 zone_id  output  2  index of the sounding zone (0..2); 2'b11 when none.
REQ-011 display_data  output  21  three 7-segment digits, active-high gfedcba; digit k = bits [7k+6:7k].

Function
REQ-012 Each sensor SHALL pass through a 2-flop synchronizer followed by a registered rising-edge detector.
REQ-013 A detected rising edge on zone k while arm=1 SHALL set pending[k] on the next edge; a level held high SHALL NOT re-trigger.
REQ-014 FSM states SHALL be one-hot IDLE, BUZZ, GAP.
REQ-015 IDLE: if any pending bit is set, the FSM SHALL grant the first pending zone found round-robin, starting at (last_granted+1) mod 3, and SHALL enter BUZZ on the next edge; otherwise it SHALL stay in IDLE.
REQ-016 BUZZ SHALL last exactly BUZZ_CYCLES cycles with LED=buzzer=1 and zone_id=granted zone, then enter GAP.
REQ-017 stop_alarm=1 sampled in BUZZ SHALL end BUZZ early: GAP is entered on the next edge; stop_alarm SHALL be ignored in IDLE and GAP.
REQ-018 Leaving BUZZ (timeout or stop_alarm) SHALL clear pending[granted] and update last_granted.
REQ-019 If a new edge on the granted zone coincides with its clear, set SHALL win (pending stays 1).
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles with LED=buzzer=0 and zone_id=2'b11, then return to IDLE.
REQ-021 End-to-end latency: with the FSM in IDLE and no other zone pending, buzzer SHALL be 1 after the 4th rising edge following the first edge that samples the sensor high.
REQ-022 arm=0 SHALL, on the next edge, clear all pending bits, force IDLE, and drive LED=buzzer=0 and zone_id=2'b11; edges arriving while arm=0 are discarded.
REQ-023 Digit k SHALL show the digit k+1 (1=0000110, 2=1011011, 3=1001111) while pending[k]=1, else 0000000.
REQ-024 The cycle counter SHALL be wide enough for max(BUZZ_CYCLES, GAP_CYCLES), SHALL reload to 0 on every state entry, and SHALL never wrap.

Reset
REQ-025 rst_n=0 SHALL immediately force: FSM=IDLE, pending=0, counter=0, synchronizer/edge flops=0, last_granted=2 (so zone 0 wins first), LED=0, buzzer=0, zone_id=2'b11, display_data=0.
REQ-026 Reset asserted mid-BUZZ SHALL silence outputs asynchronously; a sensor still high after deassertion SHALL re-trigger (edge from reset value 0).

Structure
REQ-027 Package alarm_pkg SHALL hold the state encodings, the 7-segment digit constants, the none-zone code 2'b11 and the default BUZZ_CYCLES/GAP_CYCLES values.
REQ-028 Sub-module pir_sync_edge (2-flop sync + rising-edge pulse, async active-low reset) SHALL be instantiated once per zone.

Verification
REQ-029 pir_sensor_2 pulsed high 5 cycles, arm=1 -> buzzer=1 from edge 4 for exactly 100 cycles, zone_id=1, digit1=1011011 until BUZZ ends, then 10 silent cycles.
REQ-030 All three sensors rise in the same cycle -> zones served 0,1,2 in order, each 100 cycles on, 10 off; display clears digit by digit.
REQ-031 stop_alarm pulsed at BUZZ cycle 20 -> buzzer=0 on next edge, pending for that zone cleared, GAP lasts 10 cycles.
REQ-032 Zone 0 re-triggered during its own final BUZZ cycle -> pending[0] stays 1, zone 0 served again after zones 1/2 if pending, else after GAP.
REQ-033 arm dropped mid-BUZZ with two zones pending -> next edge all outputs off, display_data=0; re-arm with sensors held high -> no alarm.
REQ-034 rst_n asserted mid-BUZZ -> outputs 0 without waiting for clk; after release, held-high sensor raises buzzer 4 edges later.
